// File: rtl/ssram_burst_model.sv
// rtl/ssram_burst_model.sv - behavioural synchronous-burst SRAM with late write and pipelined read
module ssram_burst_model #(
    parameter int DW         = 32,
    parameter int AW         = 21,
    parameter int DEPTH_LOG2 = 19,
    parameter int BURST_MODE = 0,
    parameter int RD_LAT     = 2
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic [AW-1:0]   ssram_addr,
    input  logic            ssram_ce_n,
    input  logic            ssram_adsc_n,
    input  logic            ssram_adsp_n,
    input  logic            ssram_adv_n,
    input  logic            ssram_gw_n,
    input  logic            ssram_bwe_n,
    input  logic [DW/8-1:0] ssram_be_n,
    input  logic            ssram_oe_n,
    input  logic [DW-1:0]   ssram_d,
    output logic [DW-1:0]   ssram_q,
    output logic            ssram_q_oe
);
    localparam int NB  = DW / 8;
    localparam int LSB = $clog2(NB);

    logic [DW-1:0]         mem [0:(1<<DEPTH_LOG2)-1];
    logic                  addr_valid;
    logic [DEPTH_LOG2-1:0] base;
    logic [1:0]            count;
    logic [NB-1:0]         wr_lanes;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DW-1:0]         rd_pipe [RD_LAT];

    logic                  load;
    logic                  advance;
    logic                  cmd_ok;
    logic                  valid_next;
    logic [DEPTH_LOG2-1:0] base_next;
    logic [1:0]            count_next;
    logic [NB-1:0]         lanes_next;
    logic [DEPTH_LOG2-1:0] eff;
    logic [DEPTH_LOG2-1:0] eff_next;
    logic                  unused_addr;

    assign unused_addr = ^ssram_addr;

    function automatic logic [DEPTH_LOG2-1:0] eff_of(input logic [DEPTH_LOG2-1:0] b,
                                                     input logic [1:0] c);
        logic [DEPTH_LOG2-1:0] r;
        r      = b;
        r[1:0] = (BURST_MODE != 0) ? (b[1:0] ^ c) : (b[1:0] + c);
        return r;
    endfunction

    // Any asserted strobe blocks advance, so a deselected strobe cycle leaves the burst untouched.
    assign load    = ~ssram_ce_n & (~ssram_adsc_n | ~ssram_adsp_n);
    assign advance = ~ssram_adv_n & addr_valid & ssram_adsc_n & ssram_adsp_n;
    assign cmd_ok  = ~load | ssram_adsp_n;

    always_comb begin
        base_next  = base;
        count_next = count;
        valid_next = addr_valid;
        if (load) begin
            base_next  = ssram_addr[DEPTH_LOG2+LSB-1:LSB];
            count_next = 2'd0;
            valid_next = 1'b1;
        end else if (advance) begin
            count_next = count + 2'd1;
        end
        lanes_next = '0;
        if (cmd_ok && valid_next) begin
            if (!ssram_gw_n)       lanes_next = '1;
            else if (!ssram_bwe_n) lanes_next = ~ssram_be_n;
        end
    end

    assign eff      = eff_of(base, count);
    assign eff_next = eff_of(base_next, count_next);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            addr_valid <= 1'b0;
            base       <= '0;
            count      <= 2'd0;
            wr_lanes   <= '0;
            wr_addr    <= '0;
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            addr_valid <= valid_next;
            base       <= base_next;
            count      <= count_next;
            wr_lanes   <= lanes_next;
            wr_addr    <= eff_next;
            rd_pipe[0] <= addr_valid ? mem[eff] : '0;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Late write: data arrives one edge after the command; the read above sees pre-write contents.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lanes[i]) mem[wr_addr][8*i +: 8] <= ssram_d[8*i +: 8];
        end
    end

    assign ssram_q    = rd_pipe[RD_LAT-1];
    assign ssram_q_oe = ~ssram_oe_n & addr_valid;
endmodule

// File: tb/tb_ssram_burst_model.sv
// tb/tb_ssram_burst_model.sv - directed self-checking bench for ssram_burst_model
module tb_ssram_burst_model;
    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] addr;
    logic        ce_n, adsc_n, adsp_n, adv_n, gw_n, bwe_n, oe_n;
    logic [3:0]  be_n;
    logic [31:0] d;
    logic [31:0] q2, q1, qil;
    logic        oe2, oe1, oeil;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    ssram_burst_model #(.DW(32), .AW(21), .DEPTH_LOG2(8), .BURST_MODE(0), .RD_LAT(2)) dut_lin2 (
        .sys_clk(clk), .reset(reset), .ssram_addr(addr), .ssram_ce_n(ce_n),
        .ssram_adsc_n(adsc_n), .ssram_adsp_n(adsp_n), .ssram_adv_n(adv_n),
        .ssram_gw_n(gw_n), .ssram_bwe_n(bwe_n), .ssram_be_n(be_n), .ssram_oe_n(oe_n),
        .ssram_d(d), .ssram_q(q2), .ssram_q_oe(oe2));

    ssram_burst_model #(.DW(32), .AW(21), .DEPTH_LOG2(8), .BURST_MODE(0), .RD_LAT(1)) dut_lin1 (
        .sys_clk(clk), .reset(reset), .ssram_addr(addr), .ssram_ce_n(ce_n),
        .ssram_adsc_n(adsc_n), .ssram_adsp_n(adsp_n), .ssram_adv_n(adv_n),
        .ssram_gw_n(gw_n), .ssram_bwe_n(bwe_n), .ssram_be_n(be_n), .ssram_oe_n(oe_n),
        .ssram_d(d), .ssram_q(q1), .ssram_q_oe(oe1));

    ssram_burst_model #(.DW(32), .AW(21), .DEPTH_LOG2(8), .BURST_MODE(1), .RD_LAT(2)) dut_il2 (
        .sys_clk(clk), .reset(reset), .ssram_addr(addr), .ssram_ce_n(ce_n),
        .ssram_adsc_n(adsc_n), .ssram_adsp_n(adsp_n), .ssram_adv_n(adv_n),
        .ssram_gw_n(gw_n), .ssram_bwe_n(bwe_n), .ssram_be_n(be_n), .ssram_oe_n(oe_n),
        .ssram_d(d), .ssram_q(qil), .ssram_q_oe(oeil));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce_n = 1'b0; adsc_n = 1'b1; adsp_n = 1'b1; adv_n = 1'b1;
        gw_n = 1'b1; bwe_n = 1'b1; be_n = 4'hF;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input logic [20:0] a, input logic [31:0] v);
        addr = a; adsc_n = 1'b0; gw_n = 1'b0;
        step();
        idle(); d = v;
        step();
        d = '0;
    endtask

    task automatic load(input logic [20:0] a);
        addr = a; adsc_n = 1'b0;
        step();
        idle();
    endtask

    task automatic rd_check(input logic [20:0] a, input logic [31:0] exp, input string tag);
        load(a);
        step();
        step();
        check({tag, "_lin2"}, q2, exp);
        check({tag, "_il2"}, qil, exp);
        check({tag, "_lin1"}, q1, exp);
    endtask

    initial begin
        int lin_idx[4];
        int il_idx[4];
        lin_idx = '{3, 0, 1, 2};
        il_idx  = '{3, 2, 1, 0};
        reset = 1'b1; idle(); oe_n = 1'b0; addr = '0; d = '0;
        step(); step();
        check("rst_q2", q2, 32'h0);
        check("rst_q1", q1, 32'h0);
        check("rst_oe2", {31'b0, oe2}, 32'h0);
        reset = 1'b0;
        step(); step();
        check("novalid_q2", q2, 32'h0);
        check("novalid_oe2", {31'b0, oe2}, 32'h0);

        wr_word(21'h10, 32'hDEADBEEF);
        check("valid_oe2", {31'b0, oe2}, 32'h1);
        load(21'h10);
        step();
        check("rd1_lat1", q1, 32'hDEADBEEF);
        step();
        check("rd1_lat2", q2, 32'hDEADBEEF);
        check("rd1_il", qil, 32'hDEADBEEF);

        oe_n = 1'b1; #1;
        check("oe_off_oe1", {31'b0, oe1}, 32'h0);
        check("oe_off_oe2", {31'b0, oe2}, 32'h0);
        check("oe_off_q1", q1, 32'hDEADBEEF);
        oe_n = 1'b0; #1;
        check("oe_on_oe2", {31'b0, oe2}, 32'h1);

        // deselected strobe must not reload the address
        addr = 21'h20; ce_n = 1'b1; adsc_n = 1'b0;
        step();
        idle();
        step(); step();
        check("ce_hi_q2", q2, 32'hDEADBEEF);

        wr_word(21'h20, 32'h55555555);
        addr = 21'h20; adsc_n = 1'b0; bwe_n = 1'b0; be_n = 4'b1010;
        step();
        idle(); d = 32'h11223344;
        step();
        d = '0;
        rd_check(21'h20, 32'h55225544, "bytewr");

        for (int i = 0; i < 4; i++) wr_word(21'(i * 4), 32'hA0A00000 + 32'(i));
        load(21'h0C);
        adv_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 3) adv_n = 1'b1;
            if (k <= 4) check($sformatf("burst_lin1_%0d", k), q1, 32'hA0A00000 + 32'(lin_idx[k-1]));
            if (k >= 2) begin
                check($sformatf("burst_lin2_%0d", k), q2, 32'hA0A00000 + 32'(lin_idx[k-2]));
                check($sformatf("burst_il2_%0d", k), qil, 32'hA0A00000 + 32'(il_idx[k-2]));
            end
        end

        wr_word(21'h40, 32'h12345678);
        wr_word(21'h44, 32'h9ABCDEF0);
        addr = 21'h40; adsp_n = 1'b0; bwe_n = 1'b0; be_n = 4'h0; d = 32'hFFFFFFFF;
        step();
        adsp_n = 1'b1; adv_n = 1'b0; d = 32'hCAFEF00D;
        step();
        idle(); d = 32'h0BADC0DE;
        step();
        d = '0;
        rd_check(21'h40, 32'h12345678, "adsp_nowr");
        rd_check(21'h44, 32'h0BADC0DE, "adv_wr");

        wr_word(21'h50, 32'h13579BDF);
        addr = 21'h50; adsc_n = 1'b0; gw_n = 1'b0;
        step();
        idle(); d = 32'hFFFFFFFF; reset = 1'b1;
        #1;
        check("rstmid_q2", q2, 32'h0);
        check("rstmid_q1", q1, 32'h0);
        check("rstmid_oe2", {31'b0, oe2}, 32'h0);
        step();
        reset = 1'b0; d = '0;
        step();
        rd_check(21'h50, 32'h13579BDF, "rst_discard");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ssram_burst_model.md
SSRAM_BURST_MODEL -- requirements
Module: ssram_burst_model

Interface
REQ-001 Parameter DW, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 21: byte-address width.
REQ-003 Parameter DEPTH_LOG2, default 19: log2 of the word count; the word index is addr[DEPTH_LOG2+LSB-1:LSB], with LSB = log2(DW/8).
REQ-004 Parameter BURST_MODE, default 0: 0 = linear burst, 1 = interleaved burst.
REQ-005 Parameter RD_LAT, default 2: read latency in clocks; legal values 1 or 2.
REQ-006 Ports, one per line as name / direction / width / meaning:
  sys_clk  in  1  the only clock; all logic is on its rising edge.
  reset  in  1  asynchronous, active-high.
  ssram_addr  in  AW  byte address.
  ssram_ce_n  in  1  chip enable, active low.
  ssram_adsc_n  in  1  controller address strobe, active low.
  ssram_adsp_n  in  1  processor address strobe, active low.
  ssram_adv_n  in  1  burst advance, active low.
  ssram_gw_n  in  1  global write (all lanes), active low.
  ssram_bwe_n  in  1  byte-write enable, active low.
  ssram_be_n  in  DW/8  per-lane byte enables, active low.
  ssram_oe_n  in  1  output enable, active low.
  ssram_d  in  DW  write data.
  ssram_q  out  DW  read data.
  ssram_q_oe  out  1  high when ssram_q is driven.

Function
REQ-007 Address load happens when ce_n=0 and (adsc_n=0 or adsp_n=0): the block latches the word address and clears the 2-bit burst count; it also sets addr_valid.
REQ-008 Burst advance: when adv_n=0, no load occurs and addr_valid=1, the count increments modulo 4 (it wraps 3->0).
REQ-009 Effective word address is the base with its low 2 bits replaced:
  - linear mode: (base[1:0] + count) mod 4.
  - interleaved mode: base[1:0] XOR count.
  - upper bits are never modified by a burst.
REQ-010 Simultaneous load and adv_n=0: the load wins and the count becomes 0.
REQ-011 Write command is sampled on a non-load edge, or on a load edge strobed by adsc_n alone:
  - gw_n=0 selects all lanes;
  - otherwise bwe_n=0 selects the lanes where be_n=0;
  - otherwise there is no write.
REQ-012 A load edge where adsp_n=0 ignores gw_n and bwe_n: no write is issued.
REQ-013 Late write: the lanes and effective address are registered at the command edge; the selected lanes are written from ssram_d on the next edge; the pending write then clears.
REQ-014 Back-to-back write commands on consecutive edges each commit one edge later, with no lost cycles.
REQ-015 Reads: memory is read every edge at the effective address; ssram_q presents that word exactly RD_LAT edges after the address became effective.
REQ-016 Read of a word whose write commits on the same edge returns the pre-write data (read-before-write).
REQ-017 ssram_q_oe = ~ssram_oe_n & addr_valid, combinational; ssram_q holds its last pipelined value regardless of oe_n.
REQ-018 With addr_valid=0 no write is committed and ssram_q stays at 0.
REQ-019 ce_n=1 with strobes asserted: no load; the burst state is unchanged.

Reset
REQ-020 reset=1 asynchronously clears:
  - addr_valid, base, count;
  - pending write lanes;
  - every read-pipeline stage.
  As a result ssram_q=0 and ssram_q_oe=0.
REQ-021 Memory contents are NOT cleared by reset.
REQ-022 Reset asserted mid-burst or with a write pending: the pending write is discarded; the first load after deassertion behaves as from power-up.

Verification
REQ-023 Write via gw_n=0 at addr 0x000010 with d=0xDEADBEEF, then load 0x000010 and read with RD_LAT=2 -> ssram_q=0xDEADBEEF on the 2nd edge after the load.
REQ-024 Byte write with be_n=4'b1010 and d=0x11223344 over word 0x55555555 -> read returns 0x55225544.
REQ-025 Linear burst: load 0x00000C, adv_n=0 for 3 edges -> word indices 3,0,1,2. Interleaved mode, same stimulus -> indices 3,2,1,0.
REQ-026 adsp_n=0 load with bwe_n=0 and be_n=0 -> memory unchanged; a following adv edge with bwe_n=0 writes word index base+1 (linear).
REQ-027 Assert reset one edge after a write command -> that word keeps its old value; ssram_q=0 and ssram_q_oe=0 immediately after reset asserts.
REQ-028 RD_LAT=1 build, load 0x000010 -> ssram_q=0xDEADBEEF on the 1st edge after the load; oe_n=1 -> ssram_q_oe=0 with ssram_q unchanged.
